// File: rtl/ofm_write_collector.sv
// Write-side collector for post-processed OFM words: absorbs the postprocessor stream
// in a skid FIFO and commits words to the FM buffer port whenever the reader does not own it.
`ifndef FM_BUFFER_DW
`define FM_BUFFER_DW 32
`endif
`ifndef FM_BUFFER_AW
`define FM_BUFFER_AW 12
`endif

module ofm_write_collector #(
  parameter int OFM_DW     = `FM_BUFFER_DW,
  parameter int OFM_AW     = `FM_BUFFER_AW,
  parameter int FIFO_DEPTH = 8,
  parameter int W_LVL      = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              q_start,
  input  logic [OFM_AW:0]   q_total_words,
  input  logic              pp_data_vld_i,
  input  logic [OFM_DW-1:0] pp_data_i,
  input  logic [OFM_AW-1:0] pp_addr_i,
  input  logic              rd_busy_i,
  output logic              buf_we_o,
  output logic [OFM_AW-1:0] buf_addr_o,
  output logic [OFM_DW-1:0] buf_wdata_o,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [W_LVL-1:0]  o_fifo_level
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = OFM_AW + OFM_DW;
  localparam logic [OFM_AW:0]  CNT_ONE = {{OFM_AW{1'b0}}, 1'b1};
  localparam logic [W_LVL-1:0] LVL_ONE = {{(W_LVL-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [W_LVL-1:0] LVL_FULL = W_LVL'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [OFM_AW:0]  r_total;
  logic [OFM_AW:0]  r_committed;
  logic [OFM_AW:0]  r_accepted;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [W_LVL-1:0] r_level;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];

  logic             w_run;
  logic             w_empty;
  logic             w_full;
  logic             w_pushReq;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_start;
  logic [EW-1:0]    w_inWord;
  logic [EW-1:0]    w_head;
  logic [OFM_AW:0]  w_commitNext;

  // Words beyond the layer total are refused up front so the FIFO never holds more than will be committed.
  assign w_run        = (r_state == S_RUN);
  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == LVL_FULL);
  assign w_pushReq    = w_run && pp_data_vld_i && (r_accepted != r_total);
  assign w_pop        = w_run && !rd_busy_i && (!w_empty || w_pushReq);
  assign w_push       = w_pushReq && (!w_full || w_pop);
  assign w_drop       = pp_data_vld_i && !w_push;
  assign w_start      = (r_state == S_IDLE) && q_start;
  assign w_inWord     = {pp_addr_i, pp_data_i};
  assign w_head       = w_empty ? w_inWord : r_mem[r_rdPtr];
  assign w_commitNext = r_committed + {{OFM_AW{1'b0}}, buf_we_o};
  assign o_fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_inWord;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_total     <= '0;
      r_committed <= '0;
      r_accepted  <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      buf_we_o    <= 1'b0;
      buf_addr_o  <= '0;
      buf_wdata_o <= '0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (!w_push && w_pop) r_level <= r_level - LVL_ONE;

      buf_we_o <= w_pop;
      if (w_pop) begin
        buf_addr_o  <= w_head[EW-1:OFM_DW];
        buf_wdata_o <= w_head[OFM_DW-1:0];
      end

      // A word dropped in the very cycle a layer starts still counts as an error for that layer.
      if (w_start)     o_overflow <= w_drop;
      else if (w_drop) o_overflow <= 1'b1;

      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (q_start) begin
            r_total     <= q_total_words;
            r_committed <= '0;
            r_accepted  <= '0;
            r_state     <= S_RUN;
            o_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          r_committed <= w_commitNext;
          if (w_push) r_accepted <= r_accepted + CNT_ONE;
          if (w_commitNext == r_total) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_write_collector.sv
// Directed bench for ofm_write_collector: a queue-based layer model checked on every
// negedge, plus literal expectations for latency, ordering, overflow and reset.
module tb_ofm_write_collector;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          q_start = 1'b0;
  logic [AW:0]   q_total_words = '0;
  logic          pp_data_vld_i = 1'b0;
  logic [DW-1:0] pp_data_i = '0;
  logic [AW-1:0] pp_addr_i = '0;
  logic          rd_busy_i = 1'b0;
  logic          buf_we_o;
  logic [AW-1:0] buf_addr_o;
  logic [DW-1:0] buf_wdata_o;
  logic          o_done;
  logic          o_busy;
  logic          o_overflow;
  logic [LW-1:0] o_fifo_level;

  ofm_write_collector #(
    .OFM_DW(DW), .OFM_AW(AW), .FIFO_DEPTH(DEPTH), .W_LVL(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .q_start(q_start), .q_total_words(q_total_words),
    .pp_data_vld_i(pp_data_vld_i), .pp_data_i(pp_data_i), .pp_addr_i(pp_addr_i),
    .rd_busy_i(rd_busy_i), .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o),
    .buf_wdata_o(buf_wdata_o), .o_done(o_done), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_fifo_level(o_fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nBad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Layer model: a plain queue of pending words plus counters for the current layer.
  logic [AW+DW-1:0] mQ[$];
  bit               mBusy, mDone, mOvf, mWe;
  logic [AW-1:0]    mAddr;
  logic [DW-1:0]    mData;
  int               mTotal, mCommitted, mAccepted;
  bit               reqPush, doPop, doPush, ovfSet;
  logic [AW+DW-1:0] head;

  int weCyc[$];
  int weAddr[$];
  int weData[$];
  int doneCyc = -1;

  task automatic resetModel();
    mQ.delete();
    mBusy = 0; mDone = 0; mOvf = 0; mWe = 0;
    mAddr = '0; mData = '0;
    mTotal = 0; mCommitted = 0; mAccepted = 0;
  endtask

  always @(negedge clk) begin
    if (!rstn) resetModel();
    checkOutput("we", 32'(buf_we_o), 32'(mWe));
    checkOutput("addr", 32'(buf_addr_o), 32'(mAddr));
    checkOutput("wdata", 32'(buf_wdata_o), 32'(mData));
    checkOutput("done", 32'(o_done), 32'(mDone));
    checkOutput("busy", 32'(o_busy), 32'(mBusy));
    checkOutput("overflow", 32'(o_overflow), 32'(mOvf));
    checkOutput("level", 32'(o_fifo_level), 32'(mQ.size()));
    if (buf_we_o) begin
      weCyc.push_back(cyc);
      weAddr.push_back(int'(buf_addr_o));
      weData.push_back(int'(buf_wdata_o));
    end
    if (o_done) doneCyc = cyc;
    if (rstn) begin
      if (mBusy) begin
        reqPush = pp_data_vld_i && (mAccepted < mTotal);
        doPop   = !rd_busy_i && (mQ.size() > 0 || reqPush);
        doPush  = reqPush && (mQ.size() < DEPTH || doPop);
        if (doPush) begin
          mQ.push_back({pp_addr_i, pp_data_i});
          mAccepted++;
        end
        if (doPop) begin
          head  = mQ.pop_front();
          mAddr = head[AW+DW-1:DW];
          mData = head[DW-1:0];
        end
        ovfSet = pp_data_vld_i && !doPush;
        mCommitted += int'(mWe);
        mWe = doPop;
        if (mCommitted == mTotal) begin
          mBusy = 0;
          mDone = 1;
        end
      end else begin
        mWe = 0;
        ovfSet = pp_data_vld_i;
        if (mDone) mDone = 0;
        else if (q_start) begin
          mBusy = 1; mTotal = int'(q_total_words);
          mCommitted = 0; mAccepted = 0; mOvf = 0;
        end
      end
      if (ovfSet) mOvf = 1;
    end
  end

  task automatic cycleWait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit s, input int tot, input bit v, input int a, input int d, input bit b);
    q_start       = s;
    q_total_words = tot[AW:0];
    pp_data_vld_i = v;
    pp_addr_i     = a[AW-1:0];
    pp_data_i     = d[DW-1:0];
    rd_busy_i     = b;
    cycleWait(1);
    q_start       = 1'b0;
    pp_data_vld_i = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (o_busy && n < limit) begin
      cycleWait(1);
      n++;
    end
    checkOutput("layer_finish_timeout", 32'(o_busy), 32'd0);
    cycleWait(2);
  endtask

  task automatic clearLog();
    weCyc.delete();
    weAddr.delete();
    weData.delete();
    doneCyc = -1;
  endtask

  int n0;
  int expAddr[10];

  initial begin
    cycleWait(2);
    checkOutput("rst_we", 32'(buf_we_o), 32'd0);
    checkOutput("rst_level", 32'(o_fifo_level), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    rstn = 1'b1;
    cycleWait(1);

    $display("[TB] basic stream");
    clearLog();
    applyStimulus(1, 4, 0, 0, 0, 0);
    n0 = cyc;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 'h10 + i, 'hA0 + i, 0);
    waitDone(20);
    checkOutput("basic_count", 32'(weCyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("basic_cycle", 32'((i < weCyc.size()) ? weCyc[i] : -1), 32'(n0 + 1 + i));
      checkOutput("basic_addr", 32'((i < weAddr.size()) ? weAddr[i] : -1), 32'('h10 + i));
      checkOutput("basic_data", 32'((i < weData.size()) ? weData[i] : -1), 32'('hA0 + i));
    end
    checkOutput("basic_done_cycle", 32'(doneCyc), 32'(n0 + 5));
    checkOutput("basic_ovf", 32'(o_overflow), 32'd0);

    $display("[TB] stall absorb");
    clearLog();
    applyStimulus(1, 6, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 'h20 + i, 'hB0 + i, 1);
    checkOutput("stall_level", 32'(o_fifo_level), 32'd6);
    checkOutput("stall_nowrite", 32'(weCyc.size()), 32'd0);
    rd_busy_i = 1'b0;
    waitDone(30);
    checkOutput("stall_count", 32'(weAddr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("stall_addr", 32'((i < weAddr.size()) ? weAddr[i] : -1), 32'('h20 + i));
      checkOutput("stall_data", 32'((i < weData.size()) ? weData[i] : -1), 32'('hB0 + i));
    end

    $display("[TB] overflow");
    clearLog();
    applyStimulus(1, 8, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 'h40 + i, 'hC0 + i, 1);
    checkOutput("ovf_level", 32'(o_fifo_level), 32'd8);
    checkOutput("ovf_flag", 32'(o_overflow), 32'd1);
    rd_busy_i = 1'b0;
    waitDone(30);
    checkOutput("ovf_count", 32'(weAddr.size()), 32'd8);
    checkOutput("ovf_last_addr", 32'((weAddr.size() == 8) ? weAddr[7] : -1), 32'h47);
    checkOutput("ovf_sticky", 32'(o_overflow), 32'd1);

    $display("[TB] full with simultaneous pop");
    clearLog();
    applyStimulus(1, 10, 0, 0, 0, 1);
    checkOutput("start_clears_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 'h60 + i, 'hD0 + i, 1);
    applyStimulus(0, 0, 1, 'h68, 'hD8, 1);
    checkOutput("full_drop_level", 32'(o_fifo_level), 32'd8);
    checkOutput("full_drop_ovf", 32'(o_overflow), 32'd1);
    applyStimulus(0, 0, 1, 'h69, 'hD9, 0);
    checkOutput("full_pop_level", 32'(o_fifo_level), 32'd8);
    applyStimulus(0, 0, 1, 'h6A, 'hDA, 0);
    waitDone(30);
    for (int i = 0; i < 8; i++) expAddr[i] = 'h60 + i;
    expAddr[8] = 'h69;
    expAddr[9] = 'h6A;
    checkOutput("full_count", 32'(weAddr.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      checkOutput("full_order", 32'((i < weAddr.size()) ? weAddr[i] : -1), 32'(expAddr[i]));

    $display("[TB] stray and zero-length");
    clearLog();
    applyStimulus(0, 0, 1, 'h55, 'h55, 0);
    checkOutput("stray_ovf", 32'(o_overflow), 32'd1);
    cycleWait(3);
    checkOutput("stray_nowrite", 32'(weCyc.size()), 32'd0);
    n0 = cyc;
    applyStimulus(1, 0, 0, 0, 0, 0);
    cycleWait(3);
    checkOutput("zero_done_cycle", 32'(doneCyc), 32'(n0 + 2));
    checkOutput("zero_nowrite", 32'(weCyc.size()), 32'd0);
    checkOutput("zero_ovf", 32'(o_overflow), 32'd0);

    $display("[TB] reset mid-layer");
    clearLog();
    applyStimulus(1, 5, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 'h30 + i, 'hE0 + i, 1);
    checkOutput("pre_rst_level", 32'(o_fifo_level), 32'd3);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_level", 32'(o_fifo_level), 32'd0);
    checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("mid_rst_we", 32'(buf_we_o), 32'd0);
    cycleWait(2);
    clearLog();
    rd_busy_i = 1'b0;
    rstn = 1'b1;
    cycleWait(4);
    checkOutput("post_rst_nowrite", 32'(weCyc.size()), 32'd0);
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 'h70, 'hF0, 0);
    applyStimulus(0, 0, 1, 'h71, 'hF1, 0);
    waitDone(20);
    checkOutput("relayer_count", 32'(weAddr.size()), 32'd2);
    checkOutput("relayer_addr1", 32'((weAddr.size() == 2) ? weAddr[1] : -1), 32'h71);
    checkOutput("relayer_done", 32'((doneCyc >= 0) ? 1 : 0), 32'd1);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
